// File: rtl/riscv_structures.sv
// riscv_structures: shared RV32I encodings and ALU opcode type
package riscv_structures;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
endpackage

// File: rtl/regfile.sv
// regfile: two async read ports, one sync write port, x0 reads zero
module regfile #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);
  logic [XLEN-1:0] mem [NREGS];
  always_ff @(posedge clk)
    if (we && wa != '0) mem[wa] <= wd;
  assign rd1 = ra1 == '0 ? '0 : mem[ra1];
  assign rd2 = ra2 == '0 ? '0 : mem[ra2];
endmodule

// File: rtl/decode_issue.sv
// decode_issue: in-order RV32I decode/issue stage with busy scoreboard and one-entry output register
module decode_issue
  import riscv_structures::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [31:0]     if_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_in1,
  output logic [XLEN-1:0] ex_in2,
  output alu_op_e         ex_alu_op,
  output logic [2:0]      ex_funct3,
  output logic            ex_is_branch,
  output logic [XLEN-1:0] ex_imm,
  output logic [31:0]     ex_pc,
  output logic [4:0]      ex_rd,
  output logic            ex_we,
  output logic            ex_illegal
);
  logic [6:0] opc, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic is_op, is_opi, is_br, is_lui, use1, use2, we, hazard, accept;
  logic [XLEN-1:0] rf1, rf2, v1, v2, imm_i, imm_b, imm_u;
  logic [NREGS-1:0] busy, busy_nxt;
  assign {f7, rs2, rs1, f3, rd, opc} = if_instr;
  regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk(clk), .ra1(rs1), .ra2(rs2), .rd1(rf1), .rd2(rf2),
    .we(wb_en), .wa(wb_rd), .wd(wb_data)
  );
  assign imm_i = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
  assign imm_b = {{(XLEN-12){if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
  assign imm_u = {if_instr[31:12], {(XLEN-20){1'b0}}};
  // a same-cycle writeback overrides the stale regfile value
  assign v1 = (wb_en && wb_rd == rs1 && rs1 != '0) ? wb_data : rf1;
  assign v2 = (wb_en && wb_rd == rs2 && rs2 != '0) ? wb_data : rf2;
  assign is_op  = opc == OPC_OP && f3 == 3'b000 && (f7 == F7_ADD || f7 == F7_SUB);
  assign is_opi = opc == OPC_OP_IMM && f3 == 3'b000;
  assign is_br  = opc == OPC_BRANCH && (f3 == F3_BEQ || f3 == F3_BNE || f3 == F3_BLT);
  assign is_lui = opc == OPC_LUI;
  assign use1 = opc != OPC_LUI;
  assign use2 = opc == OPC_OP || opc == OPC_BRANCH;
  assign we = (is_op || is_opi || is_lui) && rd != '0;
  assign hazard = (use1 && busy[rs1] && !(wb_en && wb_rd == rs1)) ||
                  (use2 && busy[rs2] && !(wb_en && wb_rd == rs2));
  assign if_ready = !flush && !hazard && (!ex_valid || ex_ready);
  assign accept = if_valid && if_ready;
  always_comb begin
    busy_nxt = busy;
    if (wb_en) busy_nxt[wb_rd] = 1'b0;
    if (flush && ex_valid && ex_we) busy_nxt[ex_rd] = 1'b0;
    if (accept && we) busy_nxt[rd] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy <= '0;
      ex_valid <= 1'b0;
      ex_in1 <= '0;
      ex_in2 <= '0;
      ex_alu_op <= ALU_ADD;
      ex_funct3 <= '0;
      ex_is_branch <= 1'b0;
      ex_imm <= '0;
      ex_pc <= '0;
      ex_rd <= '0;
      ex_we <= 1'b0;
      ex_illegal <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (accept) begin
        ex_valid <= 1'b1;
        ex_in1 <= is_lui ? '0 : v1;
        ex_in2 <= use2 ? v2 : is_lui ? imm_u : imm_i;
        ex_alu_op <= is_op && f7 == F7_SUB ? ALU_SUB : ALU_ADD;
        ex_funct3 <= f3;
        ex_is_branch <= is_br;
        ex_imm <= is_br ? imm_b : is_lui ? imm_u : imm_i;
        ex_pc <= if_pc;
        ex_rd <= rd;
        ex_we <= we;
        ex_illegal <= !(is_op || is_opi || is_br || is_lui);
      end else if (flush || ex_ready) ex_valid <= 1'b0;
    end
endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- In-order RV32I decode/issue stage that drives the execute-side ALU interface: operands, ALU opcode, funct3 and branch flag.
- Accepts fetched instructions over a valid/ready handshake, reads a 32x32 register file, and checks a per-register busy scoreboard.
- Holds one decoded bundle in an output register until execute accepts it.
- Consumes writebacks and branch flushes from downstream.

Parameters:
- XLEN, 32, datapath width
- NREGS, 32, architectural register count (x0 hardwired to zero)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- if_valid  in  1  fetch bundle valid
- if_ready  out  1  decode can accept this cycle
- if_instr  in  32  instruction word
- if_pc  in  32  instruction address
- wb_en  in  1  register writeback strobe
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback value
- flush  in  1  kill held bundle (branch taken in execute)
- ex_valid  out  1  issue bundle valid
- ex_ready  in  1  execute accepts bundle
- ex_in1  out  32  ALU operand 1
- ex_in2  out  32  ALU operand 2
- ex_alu_op  out  alu_op_e  ALU operation
- ex_funct3  out  3  condition select for branches
- ex_is_branch  out  1  bundle is a conditional branch
- ex_imm  out  32  immediate (branch offset for branches)
- ex_pc  out  32  pc of bundle
- ex_rd  out  5  destination register
- ex_we  out  1  bundle writes rd
- ex_illegal  out  1  unsupported encoding

Behaviour:
- Reset (async): ex_valid=0; all ex_* data outputs 0; ex_alu_op=ALU_ADD; scoreboard cleared; regfile contents undefined except x0=0.
- Handshake:
  - if_ready = !flush && !hazard && (!ex_valid || ex_ready).
  - Transfer on if_valid && if_ready; the bundle is registered, so latency is 1 cycle.
  - Outputs stay stable while ex_valid && !ex_ready.
  - ex_valid drops after the execute handshake unless a new instruction is accepted in the same cycle; back-to-back issue sustains 1 instruction/cycle.
- Decode:
  - OP (0110011): funct3=000 only; funct7=0000000 -> ALU_ADD, 0100000 -> ALU_SUB; in2=rs2.
  - OP-IMM (0010011): funct3=000 ADDI -> ALU_ADD; in2=sign-extended imm_i.
  - BRANCH (1100011): funct3 in {000,001,100}; in1=rs1, in2=rs2, is_branch=1, we=0, imm=sign-extended imm_b, alu_op=ALU_ADD.
  - LUI (0110111): in1=0, in2=imm_u, ALU_ADD.
  - Any other encoding: ex_illegal=1, ex_we=0, ex_valid=1 (execute raises the trap).
  - ex_funct3 = instr[14:12] always.
  - ex_we = 0 whenever rd==0.
- Register read:
  - x0 reads 0.
  - Write-through: if wb_en && wb_rd==rs && rs!=0, the operand takes wb_data in the same cycle.
  - Writes to x0 are ignored.
- Scoreboard:
  - busy[rd] is set when an instruction with we=1 is accepted.
  - busy[wb_rd] is cleared on wb_en.
  - If set and clear hit the same register in the same cycle, set wins.
  - hazard = (rs1 used && busy[rs1] && !(wb_en && wb_rd==rs1)), or the same test for rs2.
  - rs2 is used only by OP and BRANCH; rs1 is used by all except LUI.
- Flush:
  - Clears ex_valid next cycle and clears busy[ex_rd] if the held bundle had ex_we.
  - Blocks acceptance in that cycle.
  - Bundles already handed to execute are unaffected.
  - flush with ex_valid=0 has no effect.
  - flush has priority over ex_ready in the same cycle.

Decomposition:
- Shared package riscv_structures holds:
  - alu_op_e (existing)
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_BRANCH, OPC_LUI
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT
  - funct7 constants F7_ADD, F7_SUB
- Sub-module regfile: 2 async read ports, 1 sync write port, x0 forced zero.
- Write-through bypass lives in decode_issue, not regfile.

Test Plan:
- ADDI x1,x0,5 with ex_ready=1 -> next cycle ex_valid=1, in1=0, in2=5, ALU_ADD, rd=1, we=1; busy[1] set.
- SUB x3,x1,x2 while busy[1] set, no writeback -> if_ready=0 stalls. Then wb_en, rd=1, data=7 -> accepted that cycle with in1=7.
- BNE x1,x2,-8 -> ex_is_branch=1, funct3=001, imm=0xFFFFFFF8, we=0. With ex_ready=0 for 3 cycles, outputs are held stable.
- Held ADDI x4 (we=1) plus flush -> ex_valid=0, busy[4] cleared; same-cycle if_valid is not accepted.
- Word 0x0000007F (illegal) -> ex_illegal=1, we=0. ADDI x0,x0,1 -> we=0, scoreboard unchanged.
- Assert rst mid-stall with ex_valid=1 -> ex_valid=0 immediately (async), scoreboard empty, and the next instruction is accepted after deassert.
